// File: rtl/branch_resolve.sv
// Single-stage branch resolution: evaluates the condition, selects the next
// address and keeps saturating statistics of consumed results.
module branch_resolve #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_cond,
  input  logic [DATA_WIDTH-1:0] i_perand0,
  input  logic [DATA_WIDTH-1:0] i_perand1,
  input  logic [DATA_WIDTH-1:0] i_direct_addr,
  input  logic [DATA_WIDTH-1:0] i_offset,
  input  logic [DATA_WIDTH-1:0] i_program_addr,
  input  logic                  i_rel,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_addr,
  output logic                  o_taken,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_taken_cnt
);

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GE     = 3'd3;
  localparam logic [2:0] COND_LTU    = 3'd4;
  localparam logic [2:0] COND_GEU    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  cond_hit;
  logic                  lt_signed;
  logic                  lt_unsigned;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] next_addr;
  logic                  accept;
  logic                  consume;

  // Output slot is free when empty or being drained this cycle.
  assign o_ready = !o_valid || i_ready;

  assign accept  = i_valid && o_ready && !i_flush;
  assign consume = o_valid && i_ready && !i_flush;

  assign lt_signed   = $signed(i_perand0) < $signed(i_perand1);
  assign lt_unsigned = i_perand0 < i_perand1;

  always_comb begin
    cond_hit = 1'b0;
    case (i_cond)
      COND_EQ:     cond_hit = (i_perand0 == i_perand1);
      COND_NE:     cond_hit = (i_perand0 != i_perand1);
      COND_LT:     cond_hit = lt_signed;
      COND_GE:     cond_hit = !lt_signed;
      COND_LTU:    cond_hit = lt_unsigned;
      COND_GEU:    cond_hit = !lt_unsigned;
      COND_ALWAYS: cond_hit = 1'b1;
      default:     cond_hit = 1'b0;
    endcase
  end

  // Relative targets wrap modulo 2^DATA_WIDTH.
  assign target    = i_rel ? DATA_WIDTH'(i_program_addr + i_offset) : i_direct_addr;
  assign next_addr = cond_hit ? target : i_program_addr;

  // Result register; flush drops both the held result and the incoming request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_taken <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_addr  <= next_addr;
      o_taken <= cond_hit;
    end else if (consume) begin
      o_valid <= 1'b0;
    end
  end

  // Saturating statistics, counted only on real consumption.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_branch_cnt <= '0;
      o_taken_cnt  <= '0;
    end else if (consume) begin
      if (o_branch_cnt != CNT_MAX) begin
        o_branch_cnt <= o_branch_cnt + CNT_WIDTH'(1);
      end
      if (o_taken && (o_taken_cnt != CNT_MAX)) begin
        o_taken_cnt <= o_taken_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of operands, addresses and offsets.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port i_valid  input  1  request present.
REQ-006 SHALL have port o_ready  output  1  request accepted when i_valid && o_ready.
REQ-007 SHALL have port i_cond  input  3  condition code (see REQ-015).
REQ-008 SHALL have ports i_perand0 and i_perand1  input  DATA_WIDTH  each, compared operands.
REQ-009 SHALL have ports i_direct_addr, i_offset, i_program_addr  input  DATA_WIDTH  each: absolute target, relative offset (two's complement) and fall-through NPC.
REQ-010 SHALL have port i_rel  input  1  1 = relative target, 0 = absolute target.
REQ-011 SHALL have port i_flush  input  1  discard the in-flight result and the current input.
REQ-012 SHALL have ports o_valid  output  1  result present, and i_ready  input  1  downstream accepts; result consumed when o_valid && i_ready.
REQ-013 SHALL have ports o_addr  output  DATA_WIDTH  resolved next address, and o_taken  output  1  branch taken.
REQ-014 SHALL have ports o_branch_cnt and o_taken_cnt  output  CNT_WIDTH  each: consumed results, and consumed results with o_taken=1.

Function
REQ-015 Condition codes SHALL be: 000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110 ALWAYS, 111 NEVER; the comparison is i_perand0 vs i_perand1.
REQ-016 Target SHALL be i_rel ? (i_program_addr + i_offset) mod 2^DATA_WIDTH : i_direct_addr; wrap-around is silent.
REQ-017 o_addr SHALL be target when the condition holds, otherwise i_program_addr; o_taken SHALL equal the condition result.
REQ-018 The block SHALL be a single registered stage: a request accepted in cycle N gives o_valid=1 with its result in cycle N+1.
REQ-019 o_ready SHALL be combinationally !o_valid || i_ready, allowing one result per cycle at full throughput.
REQ-020 While o_valid && !i_ready, o_addr and o_taken SHALL hold stable and no new request SHALL be accepted.
REQ-021 On consumption without a new acceptance, o_valid SHALL go to 0 next cycle; simultaneous consumption and acceptance SHALL load the new result with o_valid staying 1.
REQ-022 i_flush=1 SHALL force o_valid=0 next cycle regardless of i_ready, and any request presented that cycle SHALL be dropped.
REQ-023 o_ready SHALL still follow REQ-019 during a flush; a dropped request is lost, not stalled.
REQ-024 Counters SHALL increment only on consumption (o_valid && i_ready && !i_flush); flushed results SHALL NOT be counted.
REQ-025 Counters SHALL saturate at all-ones and not wrap.
REQ-026 Before the first accepted request, o_addr and o_taken SHALL hold their reset values.

Reset
REQ-027 When rst_n=0 at a rising clk edge: o_valid=0, o_addr=0, o_taken=0, o_branch_cnt=0, o_taken_cnt=0.
REQ-028 Reset mid-operation SHALL discard any held result without counting it.
REQ-029 rst_n SHALL take priority over i_flush and handshakes.
REQ-030 While rst_n=0, o_ready SHALL read 1 per REQ-019, but no request SHALL be captured.

Verification
REQ-031 Cond EQ, perand0=perand1=0x55, i_rel=0, direct=0x1000, program=0x0204 -> next cycle o_valid=1, o_addr=0x1000, o_taken=1.
REQ-032 Cond LT signed, perand0=0xFFFFFFFF, perand1=1 -> taken; cond LTU with the same operands -> not taken, o_addr=i_program_addr.
REQ-033 i_rel=1, program=0xFFFFFFF0, offset=0x20 -> o_addr=0x00000010 (wrap).
REQ-034 Hold i_ready=0 for 3 cycles with a new request pending -> o_ready=0, output stable, o_branch_cnt unchanged; then i_ready=1 -> one count increment and the pending request loads the same cycle.
REQ-035 i_flush=1 with o_valid=1 and a new request present -> next cycle o_valid=0, both counters unchanged.
REQ-036 CNT_WIDTH=4, 20 consumed ALWAYS requests -> o_branch_cnt=o_taken_cnt=0xF; then rst_n=0 for one cycle -> all outputs 0.
